// File: rtl/tanimoto_batch_ctrl.sv
// tanimoto_batch_ctrl: batch sequencer placed between the vector FIFO and tanimoto_top.
// A batch runs as follows. The controller latches the threshold and the compare count,
// holds the datapath in reset for two cycles, and streams SHR_DEPTH reference vectors.
// It then streams the compare vectors and waits until the ID-pair results go quiet.
// Finally it pulses o_Done, and o_PairCnt holds the number of pairs seen in the batch.
module tanimoto_batch_ctrl #(
    parameter int BUS_WIDTH     = 512,
    parameter int VECTOR_WIDTH  = 920,
    parameter int SHR_DEPTH     = 32,
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
    parameter int VEC_CNT_WIDTH = 16,
    parameter int DRAIN_IDLE    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_Start,
    input  logic [CNT_WIDTH-1:0]     i_Threshold,
    input  logic [VEC_CNT_WIDTH-1:0] i_CmpVecCnt,
    input  logic [BUS_WIDTH-1:0]     i_Src_Vector,
    input  logic                     i_Src_Valid,
    output logic                     o_Src_Read,
    output logic [BUS_WIDTH-1:0]     o_Dp_Vector,
    output logic                     o_Dp_Valid,
    input  logic                     i_Dp_Read,
    output logic [CNT_WIDTH-1:0]     o_Dp_Threshold,
    output logic                     o_Dp_Rst,
    output logic                     o_Dp_RefPhase,
    input  logic                     i_Pair_Fire,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic [31:0]              o_PairCnt
);
    localparam int BEATS         = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int REF_BEATS     = SHR_DEPTH * BEATS;
    localparam int MAX_CMP_BEATS = ((2 ** VEC_CNT_WIDTH) - 1) * BEATS;
    localparam int MAX_BEATS     = (REF_BEATS > MAX_CMP_BEATS) ? REF_BEATS : MAX_CMP_BEATS;
    // The beat counter is wide enough for both phases, so it never wraps.
    localparam int BEAT_W        = $clog2(MAX_BEATS + 1);
    localparam int IDLE_W        = $clog2(DRAIN_IDLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD_REF, S_COMPARE, S_DRAIN, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic                cfg_second;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   cmp_beats;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [CNT_WIDTH-1:0] thr_q;
    logic [31:0]         pair_cnt;
    logic                in_stream;
    logic                beat;
    logic                ref_last;
    logic                cmp_last;
    logic                start_acc;

    assign in_stream = (state == S_LOAD_REF) || (state == S_COMPARE);
    assign beat      = o_Src_Read;
    assign ref_last  = (beat_cnt == BEAT_W'(REF_BEATS - 1));
    assign cmp_last  = (beat_cnt == cmp_beats - BEAT_W'(1));
    assign start_acc = (state == S_IDLE) && i_Start;

    assign o_Dp_Vector    = i_Src_Vector;
    assign o_Dp_Threshold = thr_q;
    assign o_PairCnt      = pair_cnt;

    // State register; reset aborts any batch in progress immediately.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection and the per-state control outputs.
    always_comb begin
        // NOTE: defaults come first so that every path assigns every output and no latch is inferred.
        state_nxt     = state;
        o_Busy        = !rst && (state != S_IDLE);
        o_Done        = !rst && (state == S_DONE);
        o_Dp_Rst      = rst || (state == S_CFG);
        o_Dp_RefPhase = !rst && (state == S_LOAD_REF);
        o_Dp_Valid    = !rst && in_stream && i_Src_Valid;
        o_Src_Read    = !rst && in_stream && i_Src_Valid && i_Dp_Read;
        case (state)
            S_IDLE:     if (i_Start) state_nxt = S_CFG;
            S_CFG:      if (cfg_second) state_nxt = S_LOAD_REF;
            S_LOAD_REF: if (beat && ref_last)
                            state_nxt = (cmp_beats == '0) ? S_DRAIN : S_COMPARE;
            S_COMPARE:  if (beat && cmp_last) state_nxt = S_DRAIN;
            S_DRAIN:    if (!i_Pair_Fire && (idle_cnt == IDLE_W'(DRAIN_IDLE - 1)))
                            state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Marks the second CFG cycle, so the datapath reset lasts exactly two cycles.
    always_ff @(posedge clk) begin
        if (rst || state != S_CFG) cfg_second <= 1'b0;
        else                       cfg_second <= 1'b1;
    end

    // Counts accepted beats within the current streaming phase and restarts at each phase boundary.
    always_ff @(posedge clk) begin
        if (rst || !in_stream) begin
            beat_cnt <= '0;
        end else if (beat) begin
            if ((state == S_LOAD_REF && ref_last) || (state == S_COMPARE && cmp_last))
                beat_cnt <= '0;
            else
                beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    // Counts consecutive DRAIN cycles with no result; each fired pair restarts the count.
    always_ff @(posedge clk) begin
        if (rst || state != S_DRAIN) idle_cnt <= '0;
        else if (i_Pair_Fire)        idle_cnt <= '0;
        else                         idle_cnt <= idle_cnt + IDLE_W'(1);
    end

    // Latches the batch configuration on an accepted start; later input changes have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q     <= '0;
            cmp_beats <= '0;
        end else if (start_acc) begin
            thr_q     <= i_Threshold;
            cmp_beats <= BEAT_W'(i_CmpVecCnt) * BEAT_W'(BEATS);
        end
    end

    // Saturating pair counter; it clears on start and counts from COMPARE through DONE.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            pair_cnt <= '0;
        end else if (i_Pair_Fire && pair_cnt != '1 &&
                     (state == S_COMPARE || state == S_DRAIN || state == S_DONE)) begin
            pair_cnt <= pair_cnt + 32'd1;
        end
    end

endmodule
